// File: rtl/color_pattern_checker_pkg.sv
// Shared colour-bar definitions: colour constants, frame geometry and band colour lookups.
// The pattern writer and the checker both take their notion of the test frame from here.
package color_pattern_checker_pkg;

  localparam int img_width      = 32;
  localparam int img_height     = 32;
  localparam int bar_width      = img_width / 8;
  localparam int bar_height     = img_height / 2;
  localparam int bar_width_mini = img_width / 32;
  localparam int bar_height_mini = img_height / 4;

  localparam logic [23:0] light_gray = 24'hc0c0c0;
  localparam logic [23:0] yellow     = 24'hc0c000;
  localparam logic [23:0] cyan       = 24'h00c0c0;
  localparam logic [23:0] green      = 24'h00c000;
  localparam logic [23:0] magenta    = 24'hc000c0;
  localparam logic [23:0] red        = 24'hc00000;
  localparam logic [23:0] blue       = 24'h0000c0;
  localparam logic [23:0] white      = 24'hffffff;
  localparam logic [23:0] dark_blue  = 24'h00214c;
  localparam logic [23:0] purple     = 24'h32006a;
  localparam logic [23:0] mid_gray0  = 24'h090909;
  localparam logic [23:0] mid_gray1  = 24'h131313;
  localparam logic [23:0] mid_gray2  = 24'h1d1d1d;

  // Upper half: the classic eight full-height bars.
  function automatic logic [23:0] top_band_color(input logic [2:0] bar);
    case (bar)
      3'd0:    return light_gray;
      3'd1:    return yellow;
      3'd2:    return cyan;
      3'd3:    return green;
      3'd4:    return magenta;
      3'd5:    return red;
      3'd6:    return blue;
      default: return white;
    endcase
  endfunction

  // Middle quarter: reverse-order castellations alternating with near-black.
  function automatic logic [23:0] mid_band_color(input logic [2:0] bar);
    case (bar)
      3'd0:    return blue;
      3'd2:    return magenta;
      3'd4:    return cyan;
      3'd6:    return light_gray;
      default: return mid_gray1;
    endcase
  endfunction

  // Bottom quarter: I/Q-style blocks on the left, PLUGE mini-bars in bar 4.
  function automatic logic [23:0] low_band_color(input logic [2:0] bar, input logic [1:0] mini);
    case (bar)
      3'd0: return dark_blue;
      3'd1: return white;
      3'd2: return purple;
      3'd4: begin
        case (mini)
          2'd0:    return mid_gray0;
          2'd1:    return mid_gray1;
          2'd2:    return mid_gray2;
          default: return mid_gray0;
        endcase
      end
      3'd6:    return light_gray;
      default: return mid_gray1;
    endcase
  endfunction

endpackage

// File: rtl/color_pattern_checker_lut.sv
// Combinational expected-colour lookup for pixel (x, y) of the colour-bar frame.
module color_pattern_lut
  import color_pattern_checker_pkg::*;
#(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int XW         = 5,
  parameter int YW         = 5
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [23:0]   expected
);

  localparam int bar_w  = IMG_WIDTH / 8;
  localparam int mini_w = IMG_WIDTH / 32;
  localparam int top_h  = IMG_HEIGHT / 2;
  localparam int mid_h  = IMG_HEIGHT / 4;

  logic [2:0] bar;
  logic [1:0] mini;

  // Pick the band by row, then the bar / mini-bar by column.
  always_comb begin
    bar  = 3'(32'(x) / bar_w);
    mini = 2'((32'(x) % bar_w) / mini_w);
    if (32'(y) < top_h) begin
      expected = top_band_color(bar);
    end else if (32'(y) < top_h + mid_h) begin
      expected = mid_band_color(bar);
    end else begin
      expected = low_band_color(bar, mini);
    end
  end

endmodule

// File: rtl/color_pattern_checker.sv
// Colour-bar frame checker: streams the test frame out of pixel RAM, compares each word
// against the expected bar colour and reports mismatch count and first failing address.
//
// state    | meaning
// ---------+---------------------------------------------------------
// st_idle  | waiting for enable; previous results held
// st_issue | one read per cycle, pixel (0,0) .. (W-1,H-1)
// st_drain | reads stopped, last READ_LATENCY compares still in flight
// st_done  | results final; waits for enable low before re-arming
module color_pattern_checker
  import color_pattern_checker_pkg::*;
#(
  parameter int          IMG_WIDTH    = 32,
  parameter int          IMG_HEIGHT   = 32,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] CMP_MASK     = 32'h00ffffff
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [17:0] starting_address,
  input  logic [31:0] data_read,
  output logic [17:0] addr,
  output logic        rden,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [10:0] error_count,
  output logic [17:0] first_error_addr
);

  localparam int xw = $clog2(IMG_WIDTH);
  localparam int yw = $clog2(IMG_HEIGHT);

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_issue = 2'd1;
  localparam logic [1:0] st_drain = 2'd2;
  localparam logic [1:0] st_done  = 2'd3;

  localparam logic [10:0] err_max = 11'h7ff;

  logic [1:0]    state_q, state_d;
  logic [17:0]   base_q, base_d;
  logic [xw-1:0] x_q, x_d;
  logic [yw-1:0] y_q, y_d;
  logic [2:0]    drain_q, drain_d;
  logic [10:0]   err_q, err_d;
  logic [17:0]   first_q, first_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic          pipe_vld_q  [READ_LATENCY];
  logic          pipe_vld_d  [READ_LATENCY];
  logic [23:0]   pipe_exp_q  [READ_LATENCY];
  logic [23:0]   pipe_exp_d  [READ_LATENCY];
  logic [17:0]   pipe_addr_q [READ_LATENCY];
  logic [17:0]   pipe_addr_d [READ_LATENCY];

  logic          issue;
  logic          last_pixel;
  logic          mismatch;
  logic [17:0]   issue_addr;
  logic [23:0]   exp_color;

  assign issue      = (state_q == st_issue);
  assign issue_addr = base_q + 18'd1 + 18'(IMG_WIDTH) * 18'(y_q) + 18'(x_q);
  assign last_pixel = (x_q == xw'(IMG_WIDTH - 1)) && (y_q == yw'(IMG_HEIGHT - 1));

  color_pattern_lut #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .XW        (xw),
    .YW        (yw)
  ) u_lut (
    .x        (x_q),
    .y        (y_q),
    .expected (exp_color)
  );

  // Expected colour and address ride alongside the RAM read so they meet its data.
  always_comb begin
    pipe_vld_d[0]  = issue;
    pipe_exp_d[0]  = exp_color;
    pipe_addr_d[0] = issue_addr;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_exp_d[i]  = pipe_exp_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
  end

  assign mismatch = pipe_vld_q[READ_LATENCY-1] &&
                    (((data_read ^ {8'h00, pipe_exp_q[READ_LATENCY-1]}) & CMP_MASK) != 32'h0);

  // Sequencing, pixel counters and result accumulation.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    x_d     = x_q;
    y_d     = y_q;
    drain_d = drain_q;
    err_d   = err_q;
    first_d = first_q;
    done_d  = done_q;
    pass_d  = pass_q;

    // A zero count means no mismatch has been seen yet, since the counter saturates.
    if (mismatch) begin
      if (err_q != err_max) err_d = err_q + 11'd1;
      if (err_q == 11'd0)   first_d = pipe_addr_q[READ_LATENCY-1];
    end

    case (state_q)
      st_idle: begin
        if (enable) begin
          state_d = st_issue;
          base_d  = starting_address;
          x_d     = '0;
          y_d     = '0;
          err_d   = '0;
          first_d = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      st_issue: begin
        if (x_q == xw'(IMG_WIDTH - 1)) begin
          x_d = '0;
          y_d = y_q + yw'(1);
        end else begin
          x_d = x_q + xw'(1);
        end
        if (last_pixel) begin
          state_d = st_drain;
          drain_d = 3'(READ_LATENCY - 1);
        end
      end
      st_drain: begin
        if (drain_q == 3'd0) begin
          state_d = st_done;
          done_d  = 1'b1;
          pass_d  = (err_d == 11'd0);
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      st_done: begin
        if (!enable) state_d = st_idle;
      end
      default: state_d = st_idle;
    endcase
  end

  // Register update; reset returns to idle with cleared results and an empty read pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= st_idle;
      base_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      drain_q <= '0;
      err_q   <= '0;
      first_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_exp_q[i]  <= '0;
        pipe_addr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      x_q     <= x_d;
      y_q     <= y_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      first_q <= first_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_d[i];
        pipe_exp_q[i]  <= pipe_exp_d[i];
        pipe_addr_q[i] <= pipe_addr_d[i];
      end
    end
  end

  assign rden             = issue;
  assign addr             = issue ? issue_addr : 18'd0;
  assign busy             = (state_q == st_issue) || (state_q == st_drain);
  assign done             = done_q;
  assign pass             = pass_q;
  assign error_count      = err_q;
  assign first_error_addr = first_q;

endmodule

// File: tb/tb_color_pattern_checker.sv
// Directed bench: three checkers (default, full-width mask, latency 3) read one shared RAM image.
module tb_color_pattern_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [17:0] starting_address;

  logic [31:0] mem [0:262143];

  logic [17:0] addr_a, addr_m, addr_l;
  logic        rden_a, rden_m, rden_l;
  logic        busy_a, busy_m, busy_l;
  logic        done_a, done_m, done_l;
  logic        pass_a, pass_m, pass_l;
  logic [10:0] err_a, err_m, err_l;
  logic [17:0] first_a, first_m, first_l;
  logic [31:0] data_a, data_m, data_l, l3_s0, l3_s1;

  int checks = 0;
  int failures = 0;
  int ca, cm, cl;

  logic [23:0] top_tab [8] = '{24'hc0c0c0, 24'hc0c000, 24'h00c0c0, 24'h00c000,
                               24'hc000c0, 24'hc00000, 24'h0000c0, 24'hffffff};
  logic [23:0] mid_tab [8] = '{24'h0000c0, 24'h131313, 24'hc000c0, 24'h131313,
                               24'h00c0c0, 24'h131313, 24'hc0c0c0, 24'h131313};
  logic [23:0] low_tab [32] = '{
    24'h00214c, 24'h00214c, 24'h00214c, 24'h00214c, 24'hffffff, 24'hffffff, 24'hffffff, 24'hffffff,
    24'h32006a, 24'h32006a, 24'h32006a, 24'h32006a, 24'h131313, 24'h131313, 24'h131313, 24'h131313,
    24'h090909, 24'h131313, 24'h1d1d1d, 24'h090909, 24'h131313, 24'h131313, 24'h131313, 24'h131313,
    24'hc0c0c0, 24'hc0c0c0, 24'hc0c0c0, 24'hc0c0c0, 24'h131313, 24'h131313, 24'h131313, 24'h131313};

  always #5 clk = ~clk;

  color_pattern_checker dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .starting_address(starting_address),
    .data_read(data_a), .addr(addr_a), .rden(rden_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .error_count(err_a), .first_error_addr(first_a));

  color_pattern_checker #(.CMP_MASK(32'hffffffff)) dut_m (
    .clk(clk), .reset_n(reset_n), .enable(enable), .starting_address(starting_address),
    .data_read(data_m), .addr(addr_m), .rden(rden_m), .busy(busy_m), .done(done_m),
    .pass(pass_m), .error_count(err_m), .first_error_addr(first_m));

  color_pattern_checker #(.READ_LATENCY(3)) dut_l (
    .clk(clk), .reset_n(reset_n), .enable(enable), .starting_address(starting_address),
    .data_read(data_l), .addr(addr_l), .rden(rden_l), .busy(busy_l), .done(done_l),
    .pass(pass_l), .error_count(err_l), .first_error_addr(first_l));

  // RAM read ports; a non-strobed read returns a poison word so misaligned compares show up.
  always @(posedge clk) begin
    data_a <= rden_a ? mem[addr_a] : 32'hdeadbeef;
    data_m <= rden_m ? mem[addr_m] : 32'hdeadbeef;
    l3_s0  <= rden_l ? mem[addr_l] : 32'hdeadbeef;
    l3_s1  <= l3_s0;
    data_l <= l3_s1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int x, input int y);
    if (y < 16)      return top_tab[x / 4];
    else if (y < 24) return mid_tab[x / 4];
    else             return low_tab[x];
  endfunction

  function automatic logic [17:0] pix_addr(input logic [17:0] base, input int x, input int y);
    return base + 18'd1 + 18'(32 * y + x);
  endfunction

  task automatic fill(input logic [17:0] base, input logic [7:0] hi);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        mem[pix_addr(base, x, y)] = {hi, exp_pix(x, y)};
  endtask

  task automatic zero_frame(input logic [17:0] base);
    for (int i = 0; i < 1024; i++) mem[base + 18'd1 + 18'(i)] = 32'h0;
  endtask

  // Pulse enable for one cycle, record the cycle each checker raises done, optionally probe addr.
  task automatic run_check(input int probe_cyc, input logic [17:0] probe_addr,
                           output int da, output int dm, output int dl);
    da = 0; dm = 0; dl = 0;
    @(posedge clk); #1 enable = 1'b1;
    for (int c = 1; c <= 1100; c++) begin
      @(posedge clk); #1;
      if (c == 1) enable = 1'b0;
      if (c == probe_cyc) begin
        check("probe_rden", {31'd0, rden_a}, 32'd1);
        check("probe_addr", {14'd0, addr_a}, {14'd0, probe_addr});
      end
      if (done_a && da == 0) da = c;
      if (done_m && dm == 0) dm = c;
      if (done_l && dl == 0) dl = c;
      if (da != 0 && dm != 0 && dl != 0) break;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    starting_address = 18'h00100;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr",  {14'd0, addr_a}, 32'd0);
    check("rst_rden",  {31'd0, rden_a}, 32'd0);
    check("rst_busy",  {31'd0, busy_a}, 32'd0);
    check("rst_done",  {31'd0, done_a}, 32'd0);
    check("rst_pass",  {31'd0, pass_a}, 32'd0);
    check("rst_err",   {21'd0, err_a}, 32'd0);
    check("rst_first", {14'd0, first_a}, 32'd0);
    reset_n = 1'b1;

    // Clean frame at 0x00100: also covers latency-3 timing
    fill(18'h00100, 8'h00);
    run_check(1, 18'h00101, ca, cm, cl);
    check("t1_cycles",   ca, 32'd1026);
    check("t1_pass",     {31'd0, pass_a}, 32'd1);
    check("t1_err",      {21'd0, err_a}, 32'd0);
    check("t1_first",    {14'd0, first_a}, 32'd0);
    check("t1_busy",     {31'd0, busy_a}, 32'd0);
    check("t1_done",     {31'd0, done_a}, 32'd1);
    check("t1_mask_pass",{31'd0, pass_m}, 32'd1);
    check("t5_l3_cycles", cl, 32'd1028);
    check("t5_l3_pass",  {31'd0, pass_l}, 32'd1);
    check("t5_l3_err",   {21'd0, err_l}, 32'd0);

    // Two corrupted pixels
    mem[pix_addr(18'h00100, 5, 3)]   = 32'h00000000;
    mem[pix_addr(18'h00100, 31, 31)] = 32'h00131312;
    run_check(3 * 32 + 5 + 1, 18'h00166, ca, cm, cl);
    check("t2_err",      {21'd0, err_a}, 32'd2);
    check("t2_pass",     {31'd0, pass_a}, 32'd0);
    check("t2_done",     {31'd0, done_a}, 32'd1);
    check("t2_first",    {14'd0, first_a}, 32'h00166);
    check("t2_l3_err",   {21'd0, err_l}, 32'd2);
    check("t2_l3_first", {14'd0, first_l}, 32'h00166);

    // Upper byte set everywhere: ignored by default mask, all fail with full mask
    fill(18'h00100, 8'hab);
    run_check(-1, 18'h0, ca, cm, cl);
    check("t3_pass",       {31'd0, pass_a}, 32'd1);
    check("t3_err",        {21'd0, err_a}, 32'd0);
    check("t3_mask_err",   {21'd0, err_m}, 32'd1024);
    check("t3_mask_pass",  {31'd0, pass_m}, 32'd0);
    check("t3_mask_first", {14'd0, first_m}, 32'h00101);

    // All-zero frame at a base that wraps through address 0
    starting_address = 18'h3fff0;
    zero_frame(18'h3fff0);
    run_check(16, 18'h00000, ca, cm, cl);
    check("t4_cycles", ca, 32'd1026);
    check("t4_err",    {21'd0, err_a}, 32'd1024);
    check("t4_first",  {14'd0, first_a}, 32'h3fff1);
    check("t4_pass",   {31'd0, pass_a}, 32'd0);
    check("t4_l3_err", {21'd0, err_l}, 32'd1024);

    // Asynchronous reset in the middle of a check with one error already counted
    starting_address = 18'h00100;
    fill(18'h00100, 8'h00);
    mem[pix_addr(18'h00100, 0, 0)] = 32'h00000000;
    @(posedge clk); #1 enable = 1'b1;
    for (int c = 1; c <= 501; c++) begin
      @(posedge clk); #1;
      if (c == 1) enable = 1'b0;
    end
    check("t6_pre_err",  {21'd0, err_a}, 32'd1);
    check("t6_pre_addr", {14'd0, addr_a}, 32'h00100 + 32'd1 + 32'd500);
    reset_n = 1'b0;
    #1;
    check("t6_addr",  {14'd0, addr_a}, 32'd0);
    check("t6_rden",  {31'd0, rden_a}, 32'd0);
    check("t6_busy",  {31'd0, busy_a}, 32'd0);
    check("t6_done",  {31'd0, done_a}, 32'd0);
    check("t6_pass",  {31'd0, pass_a}, 32'd0);
    check("t6_err",   {21'd0, err_a}, 32'd0);
    check("t6_first", {14'd0, first_a}, 32'd0);
    check("t6_l3_busy", {31'd0, busy_l}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mem[pix_addr(18'h00100, 0, 0)] = {8'h00, exp_pix(0, 0)};
    run_check(-1, 18'h0, ca, cm, cl);
    check("t6_re_cycles", ca, 32'd1026);
    check("t6_re_pass",   {31'd0, pass_a}, 32'd1);
    check("t6_re_err",    {21'd0, err_a}, 32'd0);
    check("t6_re_l3_pass",{31'd0, pass_l}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
